// File: rtl/xdma_clock_ctrl_pkg.sv
// Shared types for the XDMA-domain core clock controller.
//   ctrl_state_e : run-control FSM states
//   OP_*         : cmd_op encodings (3 is reserved: accepted and ignored)
package xdma_clock_ctrl_pkg;

  typedef enum logic [2:0] {
    StRstHold,
    StRun,
    StHaltPend,
    StHalt,
    StStep
  } ctrl_state_e;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;

endpackage

// File: rtl/xdma_clock_divider.sv
// Programmable half-period divider producing the core clock level and a
// rising-edge clock enable.
//   clock, reset_n      : XDMA clock, async active-low reset
//   tick_en_i           : divider advances when high; when low it parks at
//                         cnt=0/level=0 and adopts the pending ratio at once
//   cfg_valid_i/cfg_div_i : new half-period (0 treated as 1), last write wins
//   level_o, clock_en_o : registered divided level and its rising-edge pulse
//   rise_o, fall_o      : strobes in the cycle whose edge toggles the level
//   phase_start_low_o   : first cycle of a low phase (level=0, cnt=0)
module xdma_clock_divider #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick_en_i,
  input  logic                 cfg_valid_i,
  input  logic [CNT_WIDTH-1:0] cfg_div_i,
  output logic                 level_o,
  output logic                 clock_en_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 phase_start_low_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DefDiv =
      (DEFAULT_DIV == 0) ? CNT_WIDTH'(1) : CNT_WIDTH'(DEFAULT_DIV);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 level_q, level_d;
  logic                 clock_en_q, clock_en_d;
  logic                 wrap;

  always_comb begin
    pend_d = pend_q;
    if (cfg_valid_i) begin
      pend_d = (cfg_div_i == '0) ? CntOne : cfg_div_i;
    end

    wrap   = tick_en_i && (cnt_q == div_q - CntOne);
    rise_o = wrap && !level_q;
    fall_o = wrap && level_q;

    cnt_d   = cnt_q;
    level_d = level_q;
    div_d   = div_q;
    if (!tick_en_i) begin
      cnt_d   = '0;
      level_d = 1'b0;
      div_d   = pend_d;
    end else if (wrap) begin
      cnt_d   = '0;
      level_d = !level_q;
      // New ratio only takes effect at the start of a low phase, so a phase in
      // progress always finishes at the old length.
      if (level_q) begin
        div_d = pend_d;
      end
    end else begin
      cnt_d = cnt_q + CntOne;
    end

    clock_en_d = rise_o;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      div_q      <= DefDiv;
      pend_q     <= DefDiv;
      level_q    <= 1'b0;
      clock_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      level_q    <= level_d;
      clock_en_q <= clock_en_d;
    end
  end

  assign level_o           = level_q;
  assign clock_en_o        = clock_en_q;
  assign phase_start_low_o = !level_q && (cnt_q == '0);

endmodule

// File: rtl/xdma_clock_ctrl.sv
// Core clock run-control in the XDMA clock domain: divided core clock with
// runtime ratio, halt / single-step / re-reset control and a core cycle count.
//   clock, reset_n        : XDMA clock, async active-low reset
//   cfg_valid/cfg_div     : half-period update (cfg_ready tied high)
//   cmd_valid/cmd_op/cmd_steps, cmd_ready : RUN/HALT/STEP commands
//   core_rst_req          : level request to re-reset the core
//   core_clk_level, clock_en : divided level and its rising-edge enable
//   core_reset_n          : core reset, active low
//   halted, step_done     : run-control status
//   core_cycles           : clock_en pulses seen with the core out of reset
module xdma_clock_ctrl #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 1,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned STEP_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  output logic                  cfg_ready,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [STEP_WIDTH-1:0] cmd_steps,
  output logic                  cmd_ready,
  input  logic                  core_rst_req,
  output logic                  core_clk_level,
  output logic                  clock_en,
  output logic                  core_reset_n,
  output logic                  halted,
  output logic                  step_done,
  output logic [63:0]           core_cycles
);
  import xdma_clock_ctrl_pkg::*;

  localparam int unsigned    HoldW   = $clog2(RST_HOLD + 2);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(RST_HOLD);

  ctrl_state_e           state_q, state_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [STEP_WIDTH-1:0] remain_q, remain_d;
  logic                  step_done_q, step_done_d;
  logic                  core_reset_n_q, halted_q;
  logic [63:0]           core_cycles_q, core_cycles_d;

  logic tick_en, rise, fall, phase_start_low, cmd_acc, rst_go;

  xdma_clock_divider #(
    .CNT_WIDTH  (CNT_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_divider (
    .clock            (clock),
    .reset_n          (reset_n),
    .tick_en_i        (tick_en),
    .cfg_valid_i      (cfg_valid),
    .cfg_div_i        (cfg_div),
    .level_o          (core_clk_level),
    .clock_en_o       (clock_en),
    .rise_o           (rise),
    .fall_o           (fall),
    .phase_start_low_o(phase_start_low)
  );

  assign cfg_ready = 1'b1;
  assign cmd_ready = (state_q == StRun) || (state_q == StHalt);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign tick_en   = (state_q != StHalt);
  // Re-reset only at a clean low boundary; in HALT the divider is parked
  // at level=0/cnt=0 so this fires immediately.
  assign rst_go    = core_rst_req && (fall || phase_start_low);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    remain_d    = remain_q;
    step_done_d = 1'b0;

    if (rst_go) begin
      state_d  = StRstHold;
      hold_d   = '0;
      remain_d = '0;
    end else begin
      unique case (state_q)
        StRstHold: begin
          if (rise && (hold_q != HoldMax)) begin
            hold_d = hold_q + HoldW'(1);
          end
          if (fall && (hold_q == HoldMax)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (cmd_acc && (cmd_op == OP_HALT)) begin
            state_d = StHaltPend;
          end
        end
        StHaltPend: begin
          if (fall) begin
            state_d = StHalt;
          end
        end
        StHalt: begin
          if (cmd_acc) begin
            case (cmd_op)
              OP_RUN: state_d = StRun;
              OP_STEP: begin
                if (cmd_steps != '0) begin
                  state_d  = StStep;
                  remain_d = cmd_steps;
                end else begin
                  step_done_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        StStep: begin
          if (rise) begin
            remain_d = remain_q - STEP_WIDTH'(1);
          end
          if (fall && (remain_q == '0)) begin
            state_d     = StHalt;
            step_done_d = 1'b1;
          end
        end
        default: state_d = StRstHold;
      endcase
    end

    core_cycles_d = (state_d == StRstHold) ? '0
                  : core_cycles_q + 64'(clock_en && core_reset_n_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StRstHold;
      hold_q         <= '0;
      remain_q       <= '0;
      step_done_q    <= 1'b0;
      core_reset_n_q <= 1'b0;
      halted_q       <= 1'b0;
      core_cycles_q  <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      remain_q       <= remain_d;
      step_done_q    <= step_done_d;
      core_reset_n_q <= (state_d != StRstHold);
      halted_q       <= (state_d == StHalt);
      core_cycles_q  <= core_cycles_d;
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign halted       = halted_q;
  assign step_done    = step_done_q;
  assign core_cycles  = core_cycles_q;

endmodule

// File: tb/tb_xdma_clock_ctrl.sv
// Self-checking bench for xdma_clock_ctrl: directed scenarios followed by a
// randomized run, all checked every cycle against a phase-level model.
module tb_xdma_clock_ctrl;

  localparam int unsigned CNT_WIDTH   = 8;
  localparam int unsigned DEFAULT_DIV = 1;
  localparam int unsigned RST_HOLD    = 16;
  localparam int unsigned STEP_WIDTH  = 32;

  localparam int M_HOLD = 0, M_RUN = 1, M_HPEND = 2, M_HALT = 3, M_STEP = 4;

  logic                  clock, reset_n;
  logic                  cfg_valid, cfg_ready, cmd_valid, cmd_ready, core_rst_req;
  logic [CNT_WIDTH-1:0]  cfg_div;
  logic [1:0]            cmd_op;
  logic [STEP_WIDTH-1:0] cmd_steps;
  logic                  core_clk_level, clock_en, core_reset_n, halted, step_done;
  logic [63:0]           core_cycles;

  xdma_clock_ctrl #(
    .CNT_WIDTH  (CNT_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV),
    .RST_HOLD   (RST_HOLD),
    .STEP_WIDTH (STEP_WIDTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_valid     (cfg_valid),
    .cfg_div       (cfg_div),
    .cfg_ready     (cfg_ready),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_steps     (cmd_steps),
    .cmd_ready     (cmd_ready),
    .core_rst_req  (core_rst_req),
    .core_clk_level(core_clk_level),
    .clock_en      (clock_en),
    .core_reset_n  (core_reset_n),
    .halted        (halted),
    .step_done     (step_done),
    .core_cycles   (core_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks, failures;

  // Model: phase length bookkeeping instead of a counter; m_left is the number
  // of ticking cycles left before the level toggles.
  int unsigned     m_div, m_pend, m_left, m_rem;
  int              m_st, m_rises;
  bit              m_lvl, m_en, m_rst_n, m_halted, m_done;
  longint unsigned m_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = DEFAULT_DIV; m_pend = DEFAULT_DIV; m_left = DEFAULT_DIV; m_rem = 0;
    m_st = M_HOLD; m_rises = 0;
    m_lvl = 0; m_en = 0; m_rst_n = 0; m_halted = 0; m_done = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    int unsigned pend_n, div_n, left_n, rem_n;
    int          st_n, rises_n;
    bit          lvl_n, tick, rise, fall, ready, go, done_n;
    ready  = (m_st == M_RUN) || (m_st == M_HALT);
    pend_n = cfg_valid ? ((cfg_div == 0) ? 1 : int'(cfg_div)) : m_pend;
    tick   = (m_st != M_HALT);
    rise   = tick && (m_left == 1) && !m_lvl;
    fall   = tick && (m_left == 1) && m_lvl;
    div_n  = m_div;
    lvl_n  = m_lvl;
    if (!tick) begin
      div_n = pend_n; left_n = div_n; lvl_n = 0;
    end else if (m_left == 1) begin
      lvl_n = !m_lvl;
      if (m_lvl) div_n = pend_n;
      left_n = div_n;
    end else begin
      left_n = m_left - 1;
    end
    go      = core_rst_req && (fall || (!m_lvl && (m_left == m_div)));
    st_n    = m_st;
    rises_n = m_rises;
    rem_n   = m_rem;
    done_n  = 0;
    if (go) begin
      st_n = M_HOLD; rises_n = 0; rem_n = 0;
    end else if (m_st == M_HOLD) begin
      if (rise) rises_n = m_rises + 1;
      if (fall && (m_rises >= int'(RST_HOLD))) st_n = M_RUN;
    end else if (m_st == M_RUN) begin
      if (cmd_valid && ready && (cmd_op == 2'd1)) st_n = M_HPEND;
    end else if (m_st == M_HPEND) begin
      if (fall) st_n = M_HALT;
    end else if (m_st == M_HALT) begin
      if (cmd_valid && ready && (cmd_op == 2'd0)) st_n = M_RUN;
      if (cmd_valid && ready && (cmd_op == 2'd2)) begin
        if (cmd_steps == 0) done_n = 1;
        else begin st_n = M_STEP; rem_n = cmd_steps; end
      end
    end else begin
      if (rise) rem_n = m_rem - 1;
      if (fall && (m_rem == 0)) begin st_n = M_HALT; done_n = 1; end
    end
    m_cyc    = (st_n == M_HOLD) ? 64'd0 : m_cyc + ((m_en && m_rst_n) ? 64'd1 : 64'd0);
    m_en     = rise;
    m_rst_n  = (st_n != M_HOLD);
    m_halted = (st_n == M_HALT);
    m_done   = done_n;
    m_st     = st_n; m_rises = rises_n; m_rem = rem_n;
    m_pend   = pend_n; m_div = div_n; m_left = left_n; m_lvl = lvl_n;
  endtask

  task automatic compare();
    check("level", 64'(core_clk_level), 64'(m_lvl));
    check("clock_en", 64'(clock_en), 64'(m_en));
    check("core_reset_n", 64'(core_reset_n), 64'(m_rst_n));
    check("halted", 64'(halted), 64'(m_halted));
    check("step_done", 64'(step_done), 64'(m_done));
    check("core_cycles", core_cycles, m_cyc);
    check("cmd_ready", 64'(cmd_ready), 64'((m_st == M_RUN) || (m_st == M_HALT)));
    check("cfg_ready", 64'(cfg_ready), 64'(1));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic run_len(input bit lvl, output int len);
    len = 0;
    while ((core_clk_level == lvl) && (len < 100)) begin
      len++;
      cycle();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, 64'(core_clk_level), 64'(0));
    check({tag, "_clock_en"}, 64'(clock_en), 64'(0));
    check({tag, "_core_reset_n"}, 64'(core_reset_n), 64'(0));
    check({tag, "_halted"}, 64'(halted), 64'(0));
    check({tag, "_step_done"}, 64'(step_done), 64'(0));
    check({tag, "_core_cycles"}, core_cycles, 64'(0));
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
  endtask

  task automatic release_and_hold(input string tag);
    int n;
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (!core_reset_n && (n < 200)) begin
      cycle();
      n++;
    end
    check({tag, "_hold_cycles"}, 64'(n), 64'(2 * DEFAULT_DIV * RST_HOLD));
    check({tag, "_run_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_cycles_zero"}, core_cycles, 64'(0));
  endtask

  task automatic send_cmd(input logic [1:0] op, input int unsigned steps);
    cmd_valid = 1'b1; cmd_op = op; cmd_steps = steps;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, t, hi, lo, en_cnt, done_cnt, req_left;
    longint unsigned cc;
    checks = 0; failures = 0;
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_steps = '0; core_rst_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("por");

    // Power-on release: div=1, 16 core cycles held in reset, then RUN.
    release_and_hold("por");

    // Ratio change to 3 in a high phase, then 5 mid high phase, then 0 (=1).
    n = 0;
    while (!clock_en && (n < 20)) begin cycle(); n++; end
    cfg_valid = 1'b1; cfg_div = 8'd3; cycle(); cfg_valid = 1'b0;
    run_len(1'b0, lo);
    check("div3_low", 64'(lo), 64'(3));
    cfg_valid = 1'b1; cfg_div = 8'd5; cycle(); cfg_valid = 1'b0;
    run_len(1'b1, t);
    check("div3_high_old_ratio", 64'(t + 1), 64'(3));
    run_len(1'b0, lo);
    check("div5_low", 64'(lo), 64'(5));
    cfg_valid = 1'b1; cfg_div = 8'd0; cycle(); cfg_valid = 1'b0;
    run_len(1'b1, t);
    check("div5_high_old_ratio", 64'(t + 1), 64'(5));
    run_len(1'b0, lo);
    run_len(1'b1, hi);
    check("div0_low", 64'(lo), 64'(1));
    check("div0_high", 64'(hi), 64'(1));

    // HALT from RUN at div=1.
    check("halt_ready", 64'(cmd_ready), 64'(1));
    send_cmd(2'd1, 0);
    n = 0;
    while (!halted && (n < 50)) begin cycle(); n++; end
    check("halt_latency_ok", 64'(n <= 2), 64'(1));
    check("halt_level", 64'(core_clk_level), 64'(0));
    cc = core_cycles; en_cnt = 0;
    repeat (20) begin cycle(); if (clock_en) en_cnt++; end
    check("halt_no_en", 64'(en_cnt), 64'(0));
    check("halt_frozen", core_cycles, cc);

    // STEP 5 at div=2 (ratio applied immediately while halted).
    cfg_valid = 1'b1; cfg_div = 8'd2; cycle(); cfg_valid = 1'b0;
    cc = core_cycles; en_cnt = 0; done_cnt = 0;
    send_cmd(2'd2, 5);
    check("step_left_halt", 64'(halted), 64'(0));
    n = 0;
    while (!halted && (n < 100)) begin
      cycle(); n++;
      if (clock_en) en_cnt++;
      if (step_done) done_cnt++;
    end
    repeat (3) begin cycle(); if (clock_en) en_cnt++; if (step_done) done_cnt++; end
    check("step5_en", 64'(en_cnt), 64'(5));
    check("step5_done", 64'(done_cnt), 64'(1));
    check("step5_halted", 64'(halted), 64'(1));
    check("step5_cycles", core_cycles, cc + 64'd5);

    // STEP 0: immediate completion, no clock.
    send_cmd(2'd2, 0);
    check("step0_done", 64'(step_done), 64'(1));
    check("step0_no_en", 64'(clock_en), 64'(0));
    cycle();
    check("step0_done_pulse", 64'(step_done), 64'(0));

    // core_rst_req during a STEP: cancelled, 16 core cycles of reset, RUN.
    send_cmd(2'd2, 20);
    repeat (6) cycle();
    core_rst_req = 1'b1;
    en_cnt = 0; done_cnt = 0; n = 0;
    while (core_reset_n && (n < 50)) begin
      cycle(); n++;
      if (step_done) done_cnt++;
    end
    core_rst_req = 1'b0;
    check("rr_in_reset", 64'(core_reset_n), 64'(0));
    check("rr_cycles_zero", core_cycles, 64'(0));
    if (clock_en) en_cnt++;
    n = 0;
    while (!core_reset_n && (n < 300)) begin
      cycle(); n++;
      if (clock_en && !core_reset_n) en_cnt++;
      if (step_done) done_cnt++;
    end
    check("rr_hold_edges", 64'(en_cnt), 64'(RST_HOLD));
    check("rr_no_step_done", 64'(done_cnt), 64'(0));
    check("rr_run", 64'(cmd_ready && !halted), 64'(1));
    check("rr_cycles_restart", core_cycles, 64'(0));

    // Asynchronous reset in the middle of a STEP.
    send_cmd(2'd1, 0);
    n = 0;
    while (!halted && (n < 50)) begin cycle(); n++; end
    send_cmd(2'd2, 10);
    repeat (7) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    repeat (2) @(posedge clock);
    release_and_hold("rerun");

    // Randomized run-control, ratio and re-reset traffic.
    req_left = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = 8'($urandom_range(0, 4));
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_steps = $urandom_range(0, 3);
      if (req_left > 0) begin
        core_rst_req = 1'b1; req_left--;
      end else begin
        core_rst_req = 1'b0;
        if ($urandom_range(0, 199) == 0) req_left = $urandom_range(1, 12);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdma_clock_ctrl.md
Name: xdma_clock_ctrl

Overview:
- Control stage in the XDMA clock domain of the FPGA simulation platform.
- Produces the core clock as a clock enable plus a divided level, with a runtime-programmable divide ratio.
- Lets the host halt the core clock, single-step it N cycles, or re-reset the core.
- Feeds the core-domain clock buffer/gate and core reset; extends the fixed compile-time divider with run control.

Parameters:
CNT_WIDTH, 8, width of half-period counter and cfg_div
DEFAULT_DIV, 1, half-period in clock cycles after reset (core period = 2*div)
RST_HOLD, 16, core rising edges with core_reset_n low before release
STEP_WIDTH, 32, width of step count

Ports:
clock  in  1  XDMA clock, sole clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new divide ratio offered
cfg_div  in  CNT_WIDTH  half-period; 0 treated as 1
cfg_ready  out  1  always 1; accepted on cfg_valid
cmd_valid  in  1  run-control command offered
cmd_op  in  2  0=RUN, 1=HALT, 2=STEP, 3=reserved (accepted, ignored)
cmd_steps  in  STEP_WIDTH  rising edges for STEP
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
core_rst_req  in  1  level; request core re-reset
core_clk_level  out  1  divided clock level
clock_en  out  1  one-cycle pulse in the cycle core_clk_level rises
core_reset_n  out  1  core reset, active low
halted  out  1  state==HALT
step_done  out  1  one-cycle pulse when STEP completes
core_cycles  out  64  count of clock_en pulses with core_reset_n=1

Behaviour:
- Reset values: core_clk_level=0, clock_en=0, core_reset_n=0, halted=0, step_done=0, core_cycles=0, div=DEFAULT_DIV, cnt=0, state=RST_HOLD, cmd_ready=0.
- Divider, when ticking: cnt increments each cycle. At cnt==div-1, cnt←0 and level toggles.
  - clock_en=1 in the same cycle level goes 0→1, registered with level. Every high and low phase lasts exactly div cycles.
- Ratio update: a new cfg_div is latched as pending (last write wins). It is applied only at a 1→0 toggle, or immediately while HALT.
  - A phase already in progress always completes at the old ratio.
- States: RST_HOLD, RUN, HALT_PEND, HALT, STEP.
- RST_HOLD: divider ticks; core_reset_n=0; hold counter counts rising edges. After RST_HOLD rises, the next 1→0 toggle deasserts core_reset_n and moves to RUN. core_cycles=0 while in this state.
- RUN: ticks. HALT command → HALT_PEND. RUN and STEP commands are no-ops.
- HALT_PEND: ticks until the next 1→0 toggle, then goes to HALT with cnt=0. If level is already 0 at entry, it waits for the next 0-phase completion? No: the phase in progress ends normally. Halting happens only at a falling toggle, so level is 0 in HALT.
- HALT: no ticking, level=0, halted=1.
  - RUN → RUN.
  - STEP with n>0 → STEP with remaining=n.
  - STEP with n=0 → step_done next cycle, stay HALT.
- STEP: ticks. Each rising edge decrements remaining. At the 1→0 toggle after remaining reaches 0 → HALT and pulse step_done. Commands are not accepted.
- cmd_ready=1 only in RUN and HALT.
- core_rst_req=1: in HALT, enter RST_HOLD immediately. Otherwise enter it at the next 1→0 toggle, or immediately if level=0 at a cnt==0 boundary.
  - Pending step is cancelled without step_done; hold counter cleared.
  - It overrides a simultaneous command. The level must stay high while the request is asserted.
- core_cycles increments on clock_en when core_reset_n=1 and wraps at 2^64.
- Asynchronous reset mid-operation returns all state to reset values; no glitch requirement on level during reset.

Decomposition:
- Shared package: state enum, cmd_op encodings (OP_RUN/OP_HALT/OP_STEP).
- Natural sub-module: xdma_clock_divider, which holds cnt, level, clock_en, pending ratio, and a tick-enable input. It reports rise/fall strobes to the control FSM.

Test Plan:
- Reset, default params, div=1 → clock_en every 2nd cycle; core_reset_n rises 1 cycle after the 16th rising edge's falling toggle; state RUN; core_cycles then counts from 0.
- In RUN, cfg_div=3 written mid-high-phase → current phase ends at old length, then 3-cycle low and 3-cycle high phases; cfg_div=0 → behaves as 1.
- HALT in RUN → halted within ≤2*div cycles, level=0, no clock_en; core_cycles frozen.
- STEP cmd_steps=5 from HALT, div=2 → exactly 5 clock_en pulses, step_done once, back to HALT, core_cycles+5; STEP 0 → step_done next cycle, no clock_en.
- core_rst_req pulse during STEP → core_reset_n low, no step_done, 16 rising edges held, then RUN, core_cycles restarted at 0.
- Assert reset_n low mid-STEP → all outputs at reset values immediately (async), restart identical to scenario 1.
